// File: rtl/light_stalk_ctrl.sv
// light_stalk_ctrl: driver light stalk controller.
// Synchronises and debounces the stalk buttons, then drives the beam FSM
// (turn_li / turn_hili / beam_state) and the flash-to-pass hold (fast_hili, active-low).
// Optional follow-me-home behaviour is enabled by defining LIGHT_FOLLOW_HOME_EN.
module light_stalk_ctrl #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned FLASH_MIN  = 8,
  parameter int unsigned FMH_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_low,
  input  logic       btn_high,
  input  logic       btn_flash,
  input  logic       ign_on,
  output logic       turn_li,
  output logic       turn_hili,
  output logic       fast_hili,
  output logic [1:0] beam_state
);

  localparam int unsigned NB      = 3;
  localparam int unsigned DW      = $clog2(DEB_CYCLES + 1);
  localparam int unsigned FW      = $clog2(FLASH_MIN + 1);
  localparam int unsigned B_LOW   = 0;
  localparam int unsigned B_HIGH  = 1;
  localparam int unsigned B_FLASH = 2;
`ifdef LIGHT_FOLLOW_HOME_EN
  localparam int unsigned MW      = $clog2(FMH_CYCLES + 1);
`endif

  typedef enum logic [1:0] {
    S_OFF    = 2'b00,
    S_LOW    = 2'b01,
    S_HIGH   = 2'b10,
    S_FOLLOW = 2'b11
  } state_e;

  // Reject degenerate parameter values at elaboration
  if (DEB_CYCLES == 0 || FLASH_MIN == 0 || FMH_CYCLES == 0) begin : g_param_chk
    $error("light_stalk_ctrl: DEB_CYCLES, FLASH_MIN and FMH_CYCLES must be >= 1");
  end

  logic [NB:0]   meta_q, sync_q;     // bit NB is ignition
  logic [1:0]    rdy_q;              // synchroniser warm-up after reset
  logic [NB-1:0] lvl_q, lvl_d, lvl_prv_q, arm_q, arm_d, press_q;
  logic [DW-1:0] cnt_q [NB];
  logic [DW-1:0] cnt_d [NB];
  logic [FW-1:0] fl_cnt_q, fl_cnt_d;
  logic          fast_hili_q, fast_hili_d;
  state_e        state_q, state_d;
  logic          turn_li_q, turn_hili_q;
  logic          ign_s;
`ifdef LIGHT_FOLLOW_HOME_EN
  logic [MW-1:0] fmh_q, fmh_d;
`endif

  assign ign_s = sync_q[NB];

  // Debounce each button; a button only arms once it has been seen released,
  // so a button held through reset yields no press until released and pressed again
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = '0;
      if (sync_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          lvl_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
    arm_d = arm_q | ({NB{rdy_q[1]}} & ~sync_q[NB-1:0]);
  end

  // Flash-to-pass: hold fast_hili low for FLASH_MIN cycles or while the button is held
  always_comb begin
    fl_cnt_d    = (fl_cnt_q != '0) ? fl_cnt_q - FW'(1) : '0;
    fast_hili_d = fast_hili_q;
    if (!ign_s) begin
      fl_cnt_d    = '0;
      fast_hili_d = 1'b1;
    end else if (press_q[B_FLASH]) begin
      fl_cnt_d    = FW'(FLASH_MIN);
      fast_hili_d = 1'b0;
    end else if (fl_cnt_d == '0 && !lvl_q[B_FLASH]) begin
      fast_hili_d = 1'b1;
    end
  end

  // Beam state machine next state; losing ignition overrides button events
  always_comb begin
    state_d = state_q;
`ifdef LIGHT_FOLLOW_HOME_EN
    fmh_d   = (fmh_q != '0) ? fmh_q - MW'(1) : '0;
`endif
    unique case (state_q)
      S_OFF: begin
        if (press_q[B_LOW] && ign_s) state_d = S_LOW;
      end
      S_LOW, S_HIGH: begin
        if (!ign_s) begin
`ifdef LIGHT_FOLLOW_HOME_EN
          state_d = S_FOLLOW;
          fmh_d   = MW'(FMH_CYCLES);
`else
          state_d = S_OFF;
`endif
        end else if (press_q[B_LOW]) begin
          state_d = S_OFF;
        end else if (press_q[B_HIGH]) begin
          state_d = (state_q == S_LOW) ? S_HIGH : S_LOW;
        end
      end
      S_FOLLOW: begin
`ifdef LIGHT_FOLLOW_HOME_EN
        if (press_q[B_LOW])       state_d = S_OFF;
        else if (ign_s)           state_d = S_LOW;
        else if (fmh_q <= MW'(1)) state_d = S_OFF;
`else
        state_d = S_OFF;
`endif
      end
    endcase
  end

  // State registers; lamp outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q      <= '0;
      sync_q      <= '0;
      rdy_q       <= '0;
      lvl_q       <= '0;
      lvl_prv_q   <= '0;
      arm_q       <= '0;
      press_q     <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      fl_cnt_q    <= '0;
      fast_hili_q <= 1'b1;
      state_q     <= S_OFF;
      turn_li_q   <= 1'b0;
      turn_hili_q <= 1'b0;
`ifdef LIGHT_FOLLOW_HOME_EN
      fmh_q       <= '0;
`endif
    end else begin
      meta_q      <= {ign_on, btn_flash, btn_high, btn_low};
      sync_q      <= meta_q;
      rdy_q       <= {rdy_q[0], 1'b1};
      lvl_q       <= lvl_d;
      lvl_prv_q   <= lvl_q;
      arm_q       <= arm_d;
      press_q     <= lvl_q & ~lvl_prv_q & arm_q;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      fl_cnt_q    <= fl_cnt_d;
      fast_hili_q <= fast_hili_d;
      state_q     <= state_d;
      turn_li_q   <= (state_d != S_OFF);
      turn_hili_q <= (state_d == S_HIGH);
`ifdef LIGHT_FOLLOW_HOME_EN
      fmh_q       <= fmh_d;
`endif
    end
  end

  assign turn_li    = turn_li_q;
  assign turn_hili  = turn_hili_q;
  assign fast_hili  = fast_hili_q;
  assign beam_state = state_q;

endmodule
